// File: rtl/mips_pkg.sv
// Shared datapath constants and the writeback entry type used by the
// register-file writeback arbiter and its result FIFO.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;

  // One queued register-file write: destination and value.
  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_arbiter_fifo.sv
// Synchronous FIFO of writeback entries. Full/empty come from the occupancy
// count; pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              din,
  input  logic                   pop,
  output wb_entry_t              dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  // Push is refused when full even if a pop happens in the same cycle.
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem[rdPtr];

  // Storage write; no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Owns the register-file write port. The single-cycle ALU/load path always
// wins; multi-cycle results queue in a FIFO and drain on idle cycles. A
// busy mask tracks registers still owed by the multi-cycle unit.
module regfile_writeback_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alu_wr_en,
  input  logic [REG_W-1:0]               alu_wr_reg,
  input  logic [DATA_W-1:0]              alu_wr_data,
  input  logic                           issue_long,
  input  logic [REG_W-1:0]               issue_reg,
  input  logic                           long_valid,
  output logic                           long_ready,
  input  logic [REG_W-1:0]               long_reg,
  input  logic [DATA_W-1:0]              long_data,
  output logic                           RegWrite,
  output logic [REG_W-1:0]               WriteReg,
  output logic [DATA_W-1:0]              WriteData,
  output logic [mips_pkg::NUM_REGS-1:0]  busy_mask,
  output logic [$clog2(DEPTH):0]         fifo_count,
  output logic                           err
);

  import mips_pkg::*;

  wb_entry_t                pushEntry;
  wb_entry_t                head;
  logic                     fifoFull;
  logic                     fifoEmpty;
  logic                     aluEff;
  logic                     pushEn;
  logic                     popEn;
  logic                     violation;
  logic [NUM_REGS-1:0]      busyNext;

  assign pushEntry  = '{addr: long_reg, data: long_data};
  assign long_ready = !fifoFull;
  // A write to r0 is no write at all, so it leaves the port free for the FIFO.
  assign aluEff     = alu_wr_en && (alu_wr_reg != '0);
  assign pushEn     = long_valid && long_ready;
  assign popEn      = !aluEff && !fifoEmpty;

  wb_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushEn),
    .din   (pushEntry),
    .pop   (popEn),
    .dout  (head),
    .count (fifo_count),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  // Protocol checks use the registered busy mask; r0 is never marked busy.
  assign violation = (issue_long && busy_mask[issue_reg])
                   || (aluEff && busy_mask[alu_wr_reg])
                   || (long_valid && !long_ready);

  // Scoreboard update: clear on the pop edge, then set (set wins).
  always_comb begin
    busyNext = busy_mask;
    if (popEn) busyNext[head.addr] = 1'b0;
    if (issue_long && (issue_reg != '0)) busyNext[issue_reg] = 1'b1;
  end

  // Registered write port: ALU first, FIFO head otherwise, r0 suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (aluEff) begin
      RegWrite  <= 1'b1;
      WriteReg  <= alu_wr_reg;
      WriteData <= alu_wr_data;
    end else if (popEn && (head.addr != '0)) begin
      RegWrite  <= 1'b1;
      WriteReg  <= head.addr;
      WriteData <= head.data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  // Busy mask and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_mask <= '0;
      err       <= 1'b0;
    end else begin
      busy_mask <= busyNext;
      if (violation) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for the writeback arbiter: each task drives one scenario and
// checks registered outputs 1 time unit after the rising edge.
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_wr_en = 1'b0;
  logic [4:0]  alu_wr_reg = '0;
  logic [31:0] alu_wr_data = '0;
  logic        issue_long = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic        long_valid = 1'b0;
  logic        long_ready;
  logic [4:0]  long_reg = '0;
  logic [31:0] long_data = '0;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [31:0] busy_mask;
  logic [2:0]  fifo_count;
  logic        err;

  int tests = 0;
  int fails = 0;

  regfile_writeback_arbiter #(.DEPTH(4), .DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .alu_wr_en(alu_wr_en), .alu_wr_reg(alu_wr_reg), .alu_wr_data(alu_wr_data),
    .issue_long(issue_long), .issue_reg(issue_reg),
    .long_valid(long_valid), .long_ready(long_ready),
    .long_reg(long_reg), .long_data(long_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .busy_mask(busy_mask), .fifo_count(fifo_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_wr_en = 0; issue_long = 0; long_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    step(); step();
    tests++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL reset_regwrite got=%0b want=0", RegWrite); end
    tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL reset_busy got=%h want=0", busy_mask); end
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%0b want=0", err); end
    tests++; if (long_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%0b want=1", long_ready); end
    reset = 0;
  endtask

  task automatic test_alu_pass();
    alu_wr_en = 1; alu_wr_reg = 5; alu_wr_data = 32'hDEADBEEF;
    step();
    alu_wr_reg = 0; alu_wr_data = 32'h11111111;
    tests++; if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
      fails++; $display("FAIL alu_pass got=%0b/%0d/%h want=1/5/deadbeef", RegWrite, WriteReg, WriteData); end
    step();
    alu_wr_en = 0;
    tests++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL alu_r0 got=%0b want=0", RegWrite); end
  endtask

  task automatic test_long_idle();
    issue_long = 1; issue_reg = 9;
    step();
    issue_long = 0;
    tests++; if (busy_mask !== 32'h200) begin fails++; $display("FAIL long_busy got=%h want=200", busy_mask); end
    long_valid = 1; long_reg = 9; long_data = 32'h1234;
    step();
    long_valid = 0;
    tests++; if (RegWrite !== 1'b0 || fifo_count !== 3'd1) begin
      fails++; $display("FAIL long_nobypass got=%0b/%0d want=0/1", RegWrite, fifo_count); end
    step();
    tests++; if (RegWrite !== 1'b1 || WriteReg !== 5'd9 || WriteData !== 32'h1234) begin
      fails++; $display("FAIL long_write got=%0b/%0d/%h want=1/9/1234", RegWrite, WriteReg, WriteData); end
    tests++; if (busy_mask !== 32'h0 || fifo_count !== 3'd0) begin
      fails++; $display("FAIL long_clear got=%h/%0d want=0/0", busy_mask, fifo_count); end
  endtask

  task automatic test_arbitration();
    issue_long = 1; issue_reg = 7; long_valid = 1; long_reg = 7; long_data = 32'h77;
    step();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      alu_wr_en = 1; alu_wr_reg = 5'(i); alu_wr_data = 32'h100 + 32'(i);
      step();
      tests++; if (RegWrite !== 1'b1 || WriteReg !== 5'(i) || WriteData !== 32'h100 + 32'(i)) begin
        fails++; $display("FAIL arb_alu%0d got=%0b/%0d/%h want=1/%0d/%h", i, RegWrite, WriteReg, WriteData, i, 32'h100 + 32'(i)); end
      tests++; if (busy_mask[7] !== 1'b1 || fifo_count !== 3'd1) begin
        fails++; $display("FAIL arb_hold%0d got=%0b/%0d want=1/1", i, busy_mask[7], fifo_count); end
    end
    alu_wr_en = 0;
    step();
    tests++; if (RegWrite !== 1'b1 || WriteReg !== 5'd7 || WriteData !== 32'h77 || busy_mask !== 32'h0) begin
      fails++; $display("FAIL arb_long got=%0b/%0d/%h/%h want=1/7/77/0", RegWrite, WriteReg, WriteData, busy_mask); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      alu_wr_en = 1; alu_wr_reg = 1; alu_wr_data = 32'h5;
      issue_long = 1; issue_reg = 5'(10 + i);
      long_valid = 1; long_reg = 5'(10 + i); long_data = 32'hA0 + 32'(i);
      step();
    end
    issue_long = 0;
    tests++; if (fifo_count !== 3'd4 || long_ready !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL full_state got=%0d/%0b/%0b want=4/0/0", fifo_count, long_ready, err); end
    long_reg = 14; long_data = 32'hEE;
    step();
    long_valid = 0;
    tests++; if (err !== 1'b1 || fifo_count !== 3'd4) begin
      fails++; $display("FAIL full_overflow got=%0b/%0d want=1/4", err, fifo_count); end
    alu_wr_en = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (RegWrite !== 1'b1 || WriteReg !== 5'(10 + i) || WriteData !== 32'hA0 + 32'(i)) begin
        fails++; $display("FAIL full_drain%0d got=%0b/%0d/%h want=1/%0d/%h", i, RegWrite, WriteReg, WriteData, 10 + i, 32'hA0 + 32'(i)); end
    end
    step();
    tests++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0 || busy_mask !== 32'h0) begin
      fails++; $display("FAIL full_empty got=%0b/%0d/%h want=0/0/0", RegWrite, fifo_count, busy_mask); end
    reset = 1; step(); reset = 0;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL full_errclr got=%0b want=0", err); end
  endtask

  task automatic test_waw();
    issue_long = 1; issue_reg = 3;
    step();
    issue_long = 0;
    tests++; if (busy_mask !== 32'h8 || err !== 1'b0) begin
      fails++; $display("FAIL waw_busy got=%h/%0b want=8/0", busy_mask, err); end
    alu_wr_en = 1; alu_wr_reg = 3; alu_wr_data = 32'h33;
    step();
    alu_wr_en = 0;
    tests++; if (err !== 1'b1 || RegWrite !== 1'b1 || WriteReg !== 5'd3 || WriteData !== 32'h33) begin
      fails++; $display("FAIL waw_err got=%0b/%0b/%0d/%h want=1/1/3/33", err, RegWrite, WriteReg, WriteData); end
    reset = 1; step(); reset = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      alu_wr_en = 1; alu_wr_reg = 1; alu_wr_data = 32'h9;
      issue_long = 1; issue_reg = 5'(4 + i);
      long_valid = 1; long_reg = 5'(4 + i); long_data = 32'hC0 + 32'(i);
      step();
    end
    idle_inputs();
    tests++; if (fifo_count !== 3'd3 || busy_mask !== 32'h70) begin
      fails++; $display("FAIL mid_state got=%0d/%h want=3/70", fifo_count, busy_mask); end
    reset = 1;
    step();
    reset = 0;
    tests++; if (fifo_count !== 3'd0 || busy_mask !== 32'h0 || RegWrite !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL mid_reset got=%0d/%h/%0b/%0b want=0/0/0/0", fifo_count, busy_mask, RegWrite, err); end
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL mid_stale%0d got=%0b want=0", i, RegWrite); end
    end
  endtask

  task automatic test_back_to_back();
    alu_wr_en = 1; alu_wr_reg = 1; alu_wr_data = 32'h1;
    issue_long = 1; issue_reg = 20; long_valid = 1; long_reg = 20; long_data = 32'h20;
    step();
    alu_wr_en = 0;
    issue_reg = 21; long_reg = 21; long_data = 32'h21;
    step();
    idle_inputs();
    tests++; if (RegWrite !== 1'b1 || WriteReg !== 5'd20 || WriteData !== 32'h20 || fifo_count !== 3'd1) begin
      fails++; $display("FAIL b2b_first got=%0b/%0d/%h/%0d want=1/20/20/1", RegWrite, WriteReg, WriteData, fifo_count); end
    tests++; if (busy_mask !== 32'h0020_0000) begin fails++; $display("FAIL b2b_busy got=%h want=00200000", busy_mask); end
    step();
    tests++; if (RegWrite !== 1'b1 || WriteReg !== 5'd21 || WriteData !== 32'h21 || fifo_count !== 3'd0 || busy_mask !== 32'h0) begin
      fails++; $display("FAIL b2b_second got=%0b/%0d/%h/%0d/%h want=1/21/21/0/0", RegWrite, WriteReg, WriteData, fifo_count, busy_mask); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL b2b_err got=%0b want=0", err); end
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_long_idle();
    test_arbitration();
    test_full();
    test_waw();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
